// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - display mode encodings shared by the display source path
package disp_pkg;

  localparam logic [1:0] MODE_PC  = 2'b00;
  localparam logic [1:0] MODE_RS  = 2'b01;
  localparam logic [1:0] MODE_RT  = 2'b10;
  localparam logic [1:0] MODE_ALU = 2'b11;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus stability counter for board switches
// A new switch value is accepted only after it has held steady for CYC counted cycles.
module sw_debounce #(
  parameter int CYC = 1000000,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_sw,
  output logic [W-1:0] o_level,
  output logic         o_changed
);

  localparam int            CW   = $clog2(CYC);
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_prev;
  logic [W-1:0]  r_level;
  logic [CW-1:0] r_cnt;
  logic          r_changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_level   <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync1   <= i_sw;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_changed <= 1'b0;
      // Any wiggle, or agreement with the accepted level, restarts the stability window
      if (r_sync2 != r_prev || r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level   <= r_sync2;
        r_changed <= 1'b1;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_changed = r_changed;

endmodule

// File: rtl/disp_source_select.sv
// rtl/disp_source_select.sv - selects and freezes the CPU state pair shown on the 7-segment display
// Also generates the digit scanner clock; the scanner itself only multiplexes nibbles.
module disp_source_select
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel_sw,
  input  logic        cpu_step,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] db_data,
  output logic [7:0]  disp_hi,
  output logic [7:0]  disp_lo,
  output logic        scan_clk,
  output logic [1:0]  mode
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [1:0]    w_mode;
  logic          w_mode_changed;
  logic          w_load;
  logic [7:0]    w_map_hi;
  logic [7:0]    w_map_lo;
  logic          w_unused;

  logic          r_load_pending;
  logic [7:0]    r_disp_hi;
  logic [7:0]    r_disp_lo;
  logic [DW-1:0] r_div;
  logic          r_scan_clk;

  sw_debounce #(
    .CYC (DEBOUNCE_CYC),
    .W   (2)
  ) u_sw_debounce (
    .clk       (clk),
    .reset     (reset),
    .i_sw      (sel_sw),
    .o_level   (w_mode),
    .o_changed (w_mode_changed)
  );

  always_comb begin
    w_map_hi = pc[7:0];
    w_map_lo = next_pc[7:0];
    case (w_mode)
      MODE_PC:  begin w_map_hi = pc[7:0];            w_map_lo = next_pc[7:0]; end
      MODE_RS:  begin w_map_hi = {3'b000, rs_addr};  w_map_lo = rs_data[7:0]; end
      MODE_RT:  begin w_map_hi = {3'b000, rt_addr};  w_map_lo = rt_data[7:0]; end
      MODE_ALU: begin w_map_hi = alu_result[7:0];    w_map_lo = db_data[7:0]; end
      default:  begin w_map_hi = pc[7:0];            w_map_lo = next_pc[7:0]; end
    endcase
  end

  // w_mode already holds the new value in the cycle the change pulse is high
  assign w_load = cpu_step | w_mode_changed | r_load_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_pending <= 1'b1;
      r_disp_hi      <= '0;
      r_disp_lo      <= '0;
    end else if (w_load) begin
      r_load_pending <= 1'b0;
      r_disp_hi      <= w_map_hi;
      r_disp_lo      <= w_map_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_scan_clk <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div      <= '0;
      r_scan_clk <= ~r_scan_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_unused = &{1'b0, pc[31:8], next_pc[31:8], rs_data[31:8], rt_data[31:8],
                      alu_result[31:8], db_data[31:8]};

  assign disp_hi  = r_disp_hi;
  assign disp_lo  = r_disp_lo;
  assign scan_clk = r_scan_clk;
  assign mode     = w_mode;

endmodule

// File: tb/tb_disp_source_select.sv
// tb/tb_disp_source_select.sv - scoreboard bench for disp_source_select against a behavioural model
module tb_disp_source_select;

  localparam int SDIV = 4;
  localparam int DCYC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel_sw;
  logic        cpu_step;
  logic [31:0] pc, next_pc, rs_data, rt_data, alu_result, db_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [7:0]  disp_hi, disp_lo;
  logic        scan_clk;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_fail   = 0;

  disp_source_select #(
    .SCAN_DIV     (SDIV),
    .DEBOUNCE_CYC (DCYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_sw     (sel_sw),
    .cpu_step   (cpu_step),
    .pc         (pc),
    .next_pc    (next_pc),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .rt_addr    (rt_addr),
    .rt_data    (rt_data),
    .alu_result (alu_result),
    .db_data    (db_data),
    .disp_hi    (disp_hi),
    .disp_lo    (disp_lo),
    .scan_clk   (scan_clk),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  // Reference model: mode follows the synchronised switch once it has been seen
  // unchanged for DCYC+1 consecutive samples; the scan clock is a pure function of
  // cycles elapsed since reset.
  logic [18:0] exp_q[$];
  logic [1:0]  hist[$];
  logic [1:0]  m_mode, m_p1, m_p2;
  logic [7:0]  m_hi, m_lo;
  logic        m_pend, m_chg, m_scan, m_stable;
  int          m_k;

  function automatic logic [15:0] ref_map(input logic [1:0] m);
    case (m)
      2'b00:   return {pc[7:0], next_pc[7:0]};
      2'b01:   return {3'b000, rs_addr, rs_data[7:0]};
      2'b10:   return {3'b000, rt_addr, rt_data[7:0]};
      default: return {alu_result[7:0], db_data[7:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 2'b00; m_hi = 8'h00; m_lo = 8'h00;
      m_pend = 1'b1;  m_chg = 1'b0; m_k = 0;
      m_p1 = 2'b00;   m_p2 = 2'b00;
      hist.delete();
      for (int i = 0; i < DCYC + 1; i++) hist.push_back(2'b00);
    end else begin
      hist.push_back(m_p2);
      void'(hist.pop_front());
      if (cpu_step || m_chg || m_pend) begin
        {m_hi, m_lo} = ref_map(m_mode);
        m_pend = 1'b0;
      end
      m_chg = 1'b0;
      m_stable = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) m_stable = 1'b0;
      if (m_stable && hist[0] != m_mode) begin
        m_mode = hist[0];
        m_chg  = 1'b1;
      end
      m_p2 = m_p1;
      m_p1 = sel_sw;
      m_k++;
    end
    m_scan = ((m_k / SDIV) % 2) == 1;
    exp_q.push_back({m_hi, m_lo, m_mode, m_scan});
  end

  // Monitor: the DUT presents its full output state every cycle
  logic [18:0] got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {disp_hi, disp_lo, mode, scan_clk};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL outputs @%0t: got hi=%h lo=%h mode=%b scan=%b, expected hi=%h lo=%h mode=%b scan=%b",
                 $time, got[18:11], got[10:3], got[2:1], got[0],
                 want[18:11], want[10:3], want[2:1], want[0]);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rand_data();
    pc = $urandom; next_pc = $urandom; rs_data = $urandom; rt_data = $urandom;
    alu_result = $urandom; db_data = $urandom;
    rs_addr = 5'($urandom_range(0, 31)); rt_addr = 5'($urandom_range(0, 31));
  endtask

  int hold;

  initial begin
    reset = 1'b1; sel_sw = 2'b00; cpu_step = 1'b0;
    rand_data();
    pc = 32'h12; next_pc = 32'h16;
    tick(3);
    reset = 1'b0;
    tick(4);

    // Switch bounce shorter than the debounce window, data moving with no steps
    for (int i = 0; i < 30; i++) begin
      sel_sw = ((i / 3) % 2 == 1) ? 2'b01 : 2'b00;
      rand_data();
      tick();
    end
    sel_sw = 2'b00;
    tick(12);

    sel_sw = 2'b10; rt_addr = 5'd9; rt_data = 32'hAB;
    tick(14);

    sel_sw = 2'b11;
    tick(14);
    for (int i = 0; i < 4; i++) begin
      alu_result = $urandom; db_data = $urandom;
      tick();
    end
    cpu_step = 1'b1; alu_result = 32'h5A; db_data = 32'hC3;
    tick();
    cpu_step = 1'b0;
    tick(3);

    // Step pulse aimed at the mode-change cycle
    sel_sw = 2'b01; rs_addr = 5'd17; rs_data = 32'h3E;
    tick(11);
    cpu_step = 1'b1;
    tick();
    cpu_step = 1'b0;
    tick(4);

    // Free run, then reset in the middle of a divider count
    tick(41);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(20);

    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        sel_sw = 2'($urandom_range(0, 3));
        hold   = $urandom_range(1, 14);
      end
      hold--;
      cpu_step = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) rand_data();
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; cpu_step = 1'b0;
    tick(3);
    #1;

    n_checks++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected at most 1", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
